// File: rtl/bf_sequencer.sv
// bf_sequencer: Brainfuck instruction sequencer with loop stack, forward skip scan and output stall.
// Optional single-step input is enabled by defining BF_STEP_EN.
module bf_sequencer #(
  parameter int STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef BF_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] pc,
  input  logic [2:0] code,
  input  logic       rom_overrun,
  input  logic       cell_zero,
  output logic       cell_inc,
  output logic       cell_dec,
  output logic       ptr_inc,
  output logic       ptr_dec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       halted,
  output logic       err
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int DW  = SPW + 1;
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, SKIP = 3'd2, WAIT_OUT = 3'd3, HALT = 3'd4, ERR = 3'd5;
  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [3:0] pulse_q, pulse_d;
  logic [7:0] stack_q [STACK_DEPTH];
  logic push, adv, stall;
  logic [7:0] top;
`ifdef BF_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif
  // cell_zero lags a pulse by one cycle, so loop opcodes wait for the pulse to commit
  assign stall = (|pulse_q) && (code[2:1] == 2'b01);
  assign top   = stack_q[AW'(sp_q - 1'b1)];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    pulse_d = '0;
    push    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        pc_d    = '0;
      end
      RUN: if (rom_overrun) begin
        if (adv) state_d = HALT;
      end else if (!stall && adv) begin
        case (code)
          3'b001: state_d = WAIT_OUT;
          3'b011: if (cell_zero) begin
            state_d = SKIP;
            depth_d = DW'(1);
            pc_d    = pc_q + 8'd1;
          end else if (sp_q == FULL) state_d = ERR;
          else begin
            push = 1'b1;
            sp_d = sp_q + 1'b1;
            pc_d = pc_q + 8'd1;
          end
          3'b010: if (sp_q == '0) state_d = ERR;
          else if (!cell_zero) pc_d = top + 8'd1;
          else begin
            sp_d = sp_q - 1'b1;
            pc_d = pc_q + 8'd1;
          end
          default: begin
            pulse_d = code[2] ? 4'b0001 << code[1:0] : 4'b0000;
            pc_d    = pc_q + 8'd1;
          end
        endcase
      end
      SKIP: if (rom_overrun) begin
        if (adv) state_d = ERR;
      end else if (adv) begin
        pc_d = pc_q + 8'd1;
        if (code == 3'b011) depth_d = (&depth_q) ? depth_q : depth_q + 1'b1;
        if (code == 3'b010) begin
          depth_d = (depth_q == '0) ? depth_q : depth_q - 1'b1;
          state_d = (depth_q == DW'(1)) ? RUN : SKIP;
        end
      end
      WAIT_OUT: if (out_ready) begin
        state_d = RUN;
        pc_d    = pc_q + 8'd1;
      end
      HALT, ERR: state_d = state_q;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      pulse_q <= pulse_d;
    end
  end
  always_ff @(posedge clk) if (push) stack_q[AW'(sp_q)] <= pc_q;
  assign pc        = pc_q;
  assign cell_inc  = pulse_q[3];
  assign cell_dec  = pulse_q[2];
  assign ptr_inc   = pulse_q[1];
  assign ptr_dec   = pulse_q[0];
  assign out_valid = state_q == WAIT_OUT;
  assign busy      = (state_q == RUN) || (state_q == SKIP) || (state_q == WAIT_OUT);
  assign halted    = state_q == HALT;
  assign err       = state_q == ERR;
endmodule
